// File: rtl/cpu_ctrl_sequencer_if.sv
// Handshake, CPU-control and bus signals between the instruction source, the sequencer and cpu_8bit_top.
// slave = sequencer side, master = instruction source / datapath side.
interface cpu_ctrl_sequencer_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr;
  logic [7:0] imm;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [4:0] rsp_flags;

  logic       a_wrtn;
  logic       b_wrtn;
  logic       a_rdn;
  logic       b_rdn;
  logic [3:0] alu_opcode;
  logic       cin;
  logic       alu_sel;
  logic       alu_flag_sel;

  logic [7:0] bus_data;
  logic       bus_oe;
  logic [7:0] bus_sample;
  logic       zr;
  logic       ng;
  logic       pa;
  logic       co;
  logic       of;

  modport slave (
    input  instr_valid, instr, imm, rsp_ready, bus_sample, zr, ng, pa, co, of,
    output instr_ready, rsp_valid, rsp_data, rsp_flags,
    output a_wrtn, b_wrtn, a_rdn, b_rdn, alu_opcode, cin, alu_sel, alu_flag_sel,
    output bus_data, bus_oe
  );

  modport master (
    output instr_valid, instr, imm, rsp_ready, bus_sample, zr, ng, pa, co, of,
    input  instr_ready, rsp_valid, rsp_data, rsp_flags,
    input  a_wrtn, b_wrtn, a_rdn, b_rdn, alu_opcode, cin, alu_sel, alu_flag_sel,
    input  bus_data, bus_oe
  );
endinterface

// File: rtl/cpu_ctrl_sequencer.sv
// Micro-sequencer that turns LDA/LDB/ALU/RD instructions into cpu_8bit_top strobes and returns results.
// Optional macro CTRL_FLAG_CAPTURE_EN: adds the FCAP state and reports ALU flags in the response.
module cpu_ctrl_sequencer #(
  parameter int unsigned WRITE_CYCLES = 1,
  parameter int unsigned READ_CYCLES  = 1,
  parameter int unsigned ALU_SETTLE   = 2
) (
  input logic                 clk,
  input logic                 rst,
  cpu_ctrl_sequencer_if.slave ctl
);
  typedef enum logic [3:0] {IDLE, LOAD, TURN, READ, SETUP, EXEC, FLAG, FCAP, RESP} state_t;

  state_t      state_reg;
  logic [15:0] cnt_reg;
  logic [7:0]  imm_reg;
  logic        a_wrtn_reg;
  logic        b_wrtn_reg;
  logic        a_rdn_reg;
  logic        b_rdn_reg;
  logic [3:0]  opcode_reg;
  logic        cin_reg;
  logic        alu_sel_reg;
  logic        flag_sel_reg;
  logic [7:0]  bus_data_reg;
  logic        bus_oe_reg;
  logic        rsp_valid_reg;
  logic [7:0]  rsp_data_reg;
`ifdef CTRL_FLAG_CAPTURE_EN
  logic [4:0]  rsp_flags_reg;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      imm_reg       <= '0;
      a_wrtn_reg    <= 1'b1;
      b_wrtn_reg    <= 1'b1;
      a_rdn_reg     <= 1'b1;
      b_rdn_reg     <= 1'b1;
      opcode_reg    <= '0;
      cin_reg       <= 1'b0;
      alu_sel_reg   <= 1'b0;
      flag_sel_reg  <= 1'b0;
      bus_data_reg  <= '0;
      bus_oe_reg    <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
`ifdef CTRL_FLAG_CAPTURE_EN
      rsp_flags_reg <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (ctl.instr_valid) begin
            imm_reg <= ctl.imm;
`ifdef CTRL_FLAG_CAPTURE_EN
            rsp_flags_reg <= '0;
`endif
            case (ctl.instr[7:6])
              2'b00, 2'b01: begin
                state_reg    <= LOAD;
                cnt_reg      <= 16'(WRITE_CYCLES - 1);
                bus_oe_reg   <= 1'b1;
                bus_data_reg <= ctl.imm;
                a_wrtn_reg   <= ctl.instr[6];
                b_wrtn_reg   <= ~ctl.instr[6];
              end
              2'b11: begin
                state_reg <= READ;
                cnt_reg   <= 16'(READ_CYCLES - 1);
                a_rdn_reg <= ctl.instr[0];
                b_rdn_reg <= ~ctl.instr[0];
              end
              default: begin
                state_reg  <= SETUP;
                cnt_reg    <= 16'(ALU_SETTLE - 1);
                opcode_reg <= ctl.instr[3:0];
                cin_reg    <= ctl.instr[4];
              end
            endcase
          end
        end
        LOAD: begin
          if (cnt_reg == '0) begin
            // TURN gives the bus one idle cycle before anyone else may drive or read it
            state_reg    <= TURN;
            bus_oe_reg   <= 1'b0;
            bus_data_reg <= '0;
            a_wrtn_reg   <= 1'b1;
            b_wrtn_reg   <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 16'd1;
          end
        end
        TURN: begin
          state_reg     <= RESP;
          rsp_valid_reg <= 1'b1;
          rsp_data_reg  <= imm_reg;
        end
        READ: begin
          if (cnt_reg == '0) begin
            state_reg     <= RESP;
            rsp_data_reg  <= ctl.bus_sample;
            rsp_valid_reg <= 1'b1;
            a_rdn_reg     <= 1'b1;
            b_rdn_reg     <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 16'd1;
          end
        end
        SETUP: begin
          if (cnt_reg == '0) begin
            state_reg   <= EXEC;
            alu_sel_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 16'd1;
          end
        end
        EXEC: begin
          state_reg    <= FLAG;
          rsp_data_reg <= ctl.bus_sample;
          alu_sel_reg  <= 1'b0;
          flag_sel_reg <= 1'b1;
        end
        FLAG: begin
          flag_sel_reg <= 1'b0;
          opcode_reg   <= '0;
          cin_reg      <= 1'b0;
`ifdef CTRL_FLAG_CAPTURE_EN
          state_reg    <= FCAP;
`else
          state_reg     <= RESP;
          rsp_valid_reg <= 1'b1;
`endif
        end
`ifdef CTRL_FLAG_CAPTURE_EN
        FCAP: begin
          // flag register was loaded by the FLAG-cycle pulse, so it is valid here
          state_reg     <= RESP;
          rsp_flags_reg <= {ctl.of, ctl.co, ctl.pa, ctl.ng, ctl.zr};
          rsp_valid_reg <= 1'b1;
        end
`endif
        RESP: begin
          if (ctl.rsp_ready) begin
            state_reg     <= IDLE;
            rsp_valid_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ctl.instr_ready  = (state_reg == IDLE) && !rst;
  assign ctl.rsp_valid    = rsp_valid_reg;
  assign ctl.rsp_data     = rsp_data_reg;
`ifdef CTRL_FLAG_CAPTURE_EN
  assign ctl.rsp_flags    = rsp_flags_reg;
`else
  assign ctl.rsp_flags    = 5'b0;
`endif
  assign ctl.a_wrtn       = a_wrtn_reg;
  assign ctl.b_wrtn       = b_wrtn_reg;
  assign ctl.a_rdn        = a_rdn_reg;
  assign ctl.b_rdn        = b_rdn_reg;
  assign ctl.alu_opcode   = opcode_reg;
  assign ctl.cin          = cin_reg;
  assign ctl.alu_sel      = alu_sel_reg;
  assign ctl.alu_flag_sel = flag_sel_reg;
  assign ctl.bus_data     = bus_data_reg;
  assign ctl.bus_oe       = bus_oe_reg;
endmodule

// File: tb/tb_cpu_ctrl_sequencer.sv
// Bench for cpu_ctrl_sequencer: emulated cpu_8bit_top datapath plus an instruction-level reference model.
module tb_cpu_ctrl_sequencer;
  localparam int W = 2;
  localparam int R = 2;
  localparam int S = 2;
`ifdef CTRL_FLAG_CAPTURE_EN
  localparam bit FCAP_ON = 1'b1;
`else
  localparam bit FCAP_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  cpu_ctrl_sequencer_if ctl();

  cpu_ctrl_sequencer #(.WRITE_CYCLES(W), .READ_CYCLES(R), .ALU_SETTLE(S)) dut (
    .clk (clk),
    .rst (rst),
    .ctl (ctl)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ALU behaviour assumed for the emulated datapath: {carry, result}
  function automatic logic [8:0] alu_res(input logic [3:0] op, input logic c,
                                         input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'h0:    return {1'b0, a & b};
      4'h1:    return {1'b0, a | b};
      4'h2:    return {1'b0, a ^ b};
      4'h5:    return {1'b0, a} + {1'b0, b} + {8'd0, c};
      4'h6:    return {1'b0, a} - {1'b0, b} - {8'd0, c};
      4'hF:    return {1'b0, ~a};
      default: return {1'b0, a + {4'h0, op}};
    endcase
  endfunction

  function automatic logic [4:0] alu_flags(input logic [3:0] op, input logic c,
                                           input logic [7:0] a, input logic [7:0] b);
    logic [8:0] r;
    logic       ov;
    r  = alu_res(op, c, a, b);
    ov = (op == 4'h5) && (a[7] == b[7]) && (r[7] != a[7]);
    return {ov, r[8], ^r[7:0], r[7], r[7:0] == 8'h00};
  endfunction

  // Emulated cpu_8bit_top: registers, ALU and flag register reacting to the strobes
  logic [7:0] cpu_a = 8'h00;
  logic [7:0] cpu_b = 8'h00;
  logic [4:0] cpu_flags = 5'h00;
  logic [8:0] alu_now;

  always @(posedge clk) begin
    if (!ctl.a_wrtn && ctl.bus_oe) cpu_a <= ctl.bus_data;
    if (!ctl.b_wrtn && ctl.bus_oe) cpu_b <= ctl.bus_data;
    if (ctl.alu_flag_sel) cpu_flags <= alu_flags(ctl.alu_opcode, ctl.cin, cpu_a, cpu_b);
  end

  assign alu_now        = alu_res(ctl.alu_opcode, ctl.cin, cpu_a, cpu_b);
  assign ctl.bus_sample = !ctl.a_rdn ? cpu_a : !ctl.b_rdn ? cpu_b : ctl.alu_sel ? alu_now[7:0] : 8'hEE;
  assign {ctl.of, ctl.co, ctl.pa, ctl.ng, ctl.zr} = cpu_flags;

  // Per-cycle protocol invariants
  logic [3:0] exp_op = 4'h0;
  logic       exp_cin = 1'b0;
  int         a_run = 0;
  int         b_run = 0;

  always @(negedge clk) begin
    int strobes;
    strobes = 32'(!ctl.a_wrtn) + 32'(!ctl.b_wrtn) + 32'(!ctl.a_rdn) + 32'(!ctl.b_rdn) + 32'(ctl.alu_sel);
    check("no_contend", 32'(ctl.bus_oe & (ctl.alu_sel | ~ctl.a_rdn | ~ctl.b_rdn)), 0);
    check("one_strobe", 32'(strobes <= 1), 1);
    if (ctl.alu_sel || ctl.alu_flag_sel) begin
      check("opcode_hold", 32'(ctl.alu_opcode), 32'(exp_op));
      check("cin_hold", 32'(ctl.cin), 32'(exp_cin));
    end
    if (ctl.instr_ready) check("idle_opcode", 32'({ctl.alu_opcode, ctl.cin}), 0);
    if (ctl.rsp_valid)
      check("rsp_quiet", 32'({ctl.a_wrtn, ctl.b_wrtn, ctl.a_rdn, ctl.b_rdn, ctl.alu_sel, ctl.bus_oe}), 32'h3C);
    if (!ctl.a_wrtn) a_run++;
    else if (a_run != 0) begin
      check("a_wrtn_len", a_run, W);
      a_run = 0;
    end
    if (!ctl.b_wrtn) b_run++;
    else if (b_run != 0) begin
      check("b_wrtn_len", b_run, W);
      b_run = 0;
    end
  end

  // Instruction-level reference state
  logic [7:0] m_a = 8'h00;
  logic [7:0] m_b = 8'h00;

  task automatic run_instr(input logic [7:0] ins, input logic [7:0] imm, input int stall);
    logic [7:0] ed;
    logic [4:0] ef;
    logic [8:0] r;
    int         lat;
    int         t;
    int         n;
    ef = 5'h00;
    case (ins[7:6])
      2'b00: begin m_a = imm; ed = imm; lat = W + 2; end
      2'b01: begin m_b = imm; ed = imm; lat = W + 2; end
      2'b10: begin
        r       = alu_res(ins[3:0], ins[4], m_a, m_b);
        ed      = r[7:0];
        if (FCAP_ON) ef = alu_flags(ins[3:0], ins[4], m_a, m_b);
        lat     = S + 3 + (FCAP_ON ? 1 : 0);
        exp_op  = ins[3:0];
        exp_cin = ins[4];
      end
      default: begin ed = ins[0] ? m_b : m_a; lat = R + 1; end
    endcase
    ctl.instr       = ins;
    ctl.imm         = imm;
    ctl.instr_valid = 1'b1;
    t = 0;
    while (!ctl.instr_ready && t < 20) begin @(posedge clk); #1; t++; end
    check("accept_wait", 32'(t < 20), 1);
    @(posedge clk); #1;
    ctl.instr_valid = 1'b0;
    ctl.instr       = 8'($urandom);
    ctl.imm         = 8'($urandom);
    check("ready_busy", 32'(ctl.instr_ready), 0);
    n = 0;
    while (!ctl.rsp_valid && n < 60) begin @(posedge clk); #1; n++; end
    check("latency", n, lat - 1);
    check("rsp_data", 32'(ctl.rsp_data), 32'(ed));
    check("rsp_flags", 32'(ctl.rsp_flags), 32'(ef));
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(ctl.rsp_valid), 1);
      check("hold_data", 32'(ctl.rsp_data), 32'(ed));
      check("hold_busy", 32'(ctl.instr_ready), 0);
    end
    ctl.rsp_ready = 1'b1;
    @(posedge clk); #1;
    ctl.rsp_ready = 1'b0;
    check("retired", 32'(ctl.rsp_valid), 0);
    check("ready_after", 32'(ctl.instr_ready), 1);
    $display("instr %02h imm %02h -> data %02h flags %02h latency %0d stall %0d",
             ins, imm, ctl.rsp_data, ctl.rsp_flags, n + 1, stall);
  endtask

  task automatic reset_mid_exec();
    int t;
    ctl.instr       = 8'h95;
    ctl.imm         = 8'h00;
    exp_op          = 4'h5;
    exp_cin         = 1'b1;
    ctl.instr_valid = 1'b1;
    t = 0;
    while (!ctl.instr_ready && t < 20) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    ctl.instr_valid = 1'b0;
    t = 0;
    while (!ctl.alu_sel && t < 20) begin @(posedge clk); #1; t++; end
    check("reach_exec", 32'(t < 20), 1);
    #2 rst = 1'b1;
    #1;
    check("rst_strobes", 32'({ctl.a_wrtn, ctl.b_wrtn, ctl.a_rdn, ctl.b_rdn,
                              ctl.alu_sel, ctl.alu_flag_sel, ctl.bus_oe, ctl.rsp_valid}), 32'hF0);
    check("rst_opcode", 32'({ctl.alu_opcode, ctl.cin}), 0);
    check("rst_ready", 32'(ctl.instr_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_idle", 32'(ctl.instr_ready), 1);
    check("rst_no_rsp", 32'(ctl.rsp_valid), 0);
    $display("reset during EXEC: strobes released, response discarded");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ri;
    logic [7:0] rm;
    ctl.instr_valid = 1'b0;
    ctl.instr       = 8'h00;
    ctl.imm         = 8'h00;
    ctl.rsp_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_strobes", 32'({ctl.a_wrtn, ctl.b_wrtn, ctl.a_rdn, ctl.b_rdn,
                                ctl.alu_sel, ctl.alu_flag_sel, ctl.bus_oe, ctl.rsp_valid}), 32'hF0);
    check("reset_values", 32'({ctl.alu_opcode, ctl.cin, ctl.bus_data, ctl.rsp_data, ctl.rsp_flags}), 0);
    check("reset_ready", 32'(ctl.instr_ready), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_out_of_reset", 32'(ctl.instr_ready), 1);

    run_instr(8'h00, 8'hA5, 0);
    run_instr(8'h40, 8'h5A, 0);
    run_instr(8'hC0, 8'h11, 0);
    run_instr(8'hC1, 8'h22, 0);
    run_instr(8'h00, 8'h03, 0);
    run_instr(8'h40, 8'h04, 0);
    run_instr(8'h95, 8'h00, 0);
    run_instr(8'h00, 8'hCC, 0);
    run_instr(8'h8F, 8'h00, 0);
    run_instr(8'hC0, 8'h00, 5);
    run_instr(8'h00, 8'h70, 0);
    run_instr(8'h40, 8'h40, 1);
    run_instr(8'h85, 8'h00, 2);
    run_instr(8'h00, 8'h00, 0);
    run_instr(8'h80, 8'h00, 0);
    run_instr(8'hFE, 8'h00, 0);

    reset_mid_exec();
    run_instr(8'hC0, 8'h00, 0);
    run_instr(8'hC1, 8'h00, 0);

    for (int i = 0; i < 60; i++) begin
      ri = 8'($urandom);
      rm = 8'($urandom);
      run_instr(ri, rm, int'($urandom_range(0, 3)));
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
